// File: rtl/intra_pkg.sv
// Shared definitions for the intra-frame macroblock blocks: default macroblock
// geometry, the writer state encoding and a counter-width helper.
package intra_pkg;

  localparam int MB_SIZE_L_DFLT = 16;
  localparam int MB_SIZE_W_DFLT = 16;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    DONE
  } mb_wr_state_t;

  // Counter width for n values; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mb_addr_gen.sv
// Frame address and clip flag for pixel (j,k) of a macroblock anchored at
// (row,col). All arithmetic is 32-bit; the address is truncated at the port.
module mb_addr_gen #(
  parameter int WIDTH  = 1280,
  parameter int LENGTH = 720,
  parameter int JW     = 4,
  parameter int KW     = 4,
  parameter int ADDR_W = 20
) (
  input  logic [15:0]       row,
  input  logic [15:0]       col,
  input  logic [JW-1:0]     j,
  input  logic [KW-1:0]     k,
  output logic [ADDR_W-1:0] addr,
  output logic              clip
);

  logic [31:0] row_abs;
  logic [31:0] col_abs;

  always_comb begin
    row_abs = 32'(row) + 32'(j);
    col_abs = 32'(col) + 32'(k);
    clip    = (row_abs >= 32'(LENGTH)) || (col_abs >= 32'(WIDTH));
    addr    = ADDR_W'(row_abs * 32'(WIDTH) + col_abs);
  end

endmodule

// File: rtl/mb_writer.sv
// Writes one buffered macroblock into frame memory in raster order, skipping
// pixels outside the frame and stalling on mem_ready for in-frame pixels.
module mb_writer
  import intra_pkg::*;
#(
  parameter int  WIDTH     = 1280,
  parameter int  LENGTH    = 720,
  parameter int  MB_SIZE_L = MB_SIZE_L_DFLT,
  parameter int  MB_SIZE_W = MB_SIZE_W_DFLT,
  localparam int ADDR_W    = $clog2(WIDTH * LENGTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       mbnumber,
  input  logic [7:0]        mb [MB_SIZE_L*MB_SIZE_W],
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ready,
  output logic              done
);

  localparam int NPIX  = MB_SIZE_L * MB_SIZE_W;
  localparam int JW    = cnt_w(MB_SIZE_L);
  localparam int KW    = cnt_w(MB_SIZE_W);
  localparam int IDX_W = cnt_w(NPIX);

  mb_wr_state_t      state_q;
  logic [JW-1:0]     j_q, j_n;
  logic [KW-1:0]     k_q, k_n;
  logic [15:0]       row_q, row_n;
  logic [15:0]       col_q, col_n;
  logic [7:0]        buf_q [NPIX];
  logic [IDX_W-1:0]  idx_n;
  logic [7:0]        wdata_n;
  logic [ADDR_W-1:0] addr_n;
  logic              clip_n;
  logic              xfer, adv, last, load;

  assign in_ready = (state_q == IDLE);

  // Outputs are registered, so the next pixel (j_n,k_n) is computed one cycle
  // ahead. In WRITE, mem_we low means the current pixel is clipped.
  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    xfer  = (state_q == IDLE) && in_valid;
    adv   = (state_q == WRITE) && (!mem_we || mem_ready);
    last  = (j_q == JW'(MB_SIZE_L - 1)) && (k_q == KW'(MB_SIZE_W - 1));
    row_n = row_q;
    col_n = col_q;
    j_n   = j_q;
    k_n   = k_q;
    if (xfer) begin
      row_n = mbnumber[31:16];
      col_n = mbnumber[15:0];
      j_n   = '0;
      k_n   = '0;
    end else if (adv && !last) begin
      if (k_q == KW'(MB_SIZE_W - 1)) begin
        k_n = '0;
        j_n = j_q + JW'(1);
      end else begin
        k_n = k_q + KW'(1);
      end
    end
    load    = xfer || (adv && !last);
    idx_n   = IDX_W'(32'(j_n) * 32'(MB_SIZE_W) + 32'(k_n));
    wdata_n = xfer ? mb[idx_n] : buf_q[idx_n];
  end

  mb_addr_gen #(
    .WIDTH (WIDTH),
    .LENGTH(LENGTH),
    .JW    (JW),
    .KW    (KW),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .row (row_n),
    .col (col_n),
    .j   (j_n),
    .k   (k_n),
    .addr(addr_n),
    .clip(clip_n)
  );

  // NOTE: pixel storage has no reset; its contents are only read after a transfer loads it.
  always_ff @(posedge clk) begin
    if (xfer) buf_q <= mb;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      j_q       <= '0;
      k_q       <= '0;
      row_q     <= '0;
      col_q     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        row_q     <= row_n;
        col_q     <= col_n;
        j_q       <= j_n;
        k_q       <= k_n;
        mem_we    <= !clip_n;
        mem_addr  <= addr_n;
        mem_wdata <= wdata_n;
      end
      case (state_q)
        IDLE:    if (xfer) state_q <= WRITE;
        WRITE: begin
          if (adv && last) begin
            state_q <= DONE;
            mem_we  <= 1'b0;
            done    <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mb_writer.sv
// Self-checking bench for mb_writer: directed and randomized macroblocks are
// compared against a queue of expected (address, pixel) writes in raster order.
module tb_mb_writer;

  localparam int WIDTH  = 1280;
  localparam int LENGTH = 720;
  localparam int L      = 16;
  localparam int W      = 16;
  localparam int NPIX   = L * W;
  localparam int ADDR_W = $clog2(WIDTH * LENGTH);

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       mbnumber;
  logic [7:0]        mb [NPIX];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ready;
  logic              done;

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  mb_writer #(
    .WIDTH    (WIDTH),
    .LENGTH   (LENGTH),
    .MB_SIZE_L(L),
    .MB_SIZE_W(W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mbnumber (mbnumber),
    .mb       (mb),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .done     (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode: 0 = mem_ready always 1, 1 = toggling, 2 = random.
  // abort_at >= 0 pulls reset low once that many writes have been accepted.
  // hammer keeps in_valid high with changing mb for the whole transfer.
  task automatic run_block(input int row, input int col, input int mode, input bit ramp,
                           input int abort_at, input bit hammer);
    logic [7:0]        pix [NPIX];
    wr_t               e;
    int                cyc, nwr;
    bit                fin, prev_stall;
    logic [ADDR_W-1:0] prev_addr;
    logic [7:0]        prev_data;

    for (int i = 0; i < NPIX; i++) pix[i] = ramp ? 8'(i) : 8'($urandom);
    exp_q.delete();
    for (int j = 0; j < L; j++)
      for (int k = 0; k < W; k++)
        if (row + j < LENGTH && col + k < WIDTH)
          exp_q.push_back('{32'((row + j) * WIDTH + col + k), pix[j * W + k]});

    @(negedge clk);
    check("idle_ready", 32'(in_ready), 1);
    check("idle_done", 32'(done), 0);
    check("idle_we", 32'(mem_we), 0);
    mbnumber = {16'(row), 16'(col)};
    for (int i = 0; i < NPIX; i++) mb[i] = pix[i];
    in_valid  = 1'b1;
    mem_ready = 1'b1;

    cyc = 0; nwr = 0; fin = 0; prev_stall = 0;
    prev_addr = '0; prev_data = '0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      in_valid = hammer;
      if (hammer) for (int i = 0; i < NPIX; i++) mb[i] = 8'($urandom);
      if (mode == 0)      mem_ready = 1'b1;
      else if (mode == 1) mem_ready = (cyc % 2) == 1;
      else                mem_ready = 1'($urandom);

      check("busy_ready", 32'(in_ready), 0);
      if (prev_stall) begin
        check("stall_we", 32'(mem_we), 1);
        check("stall_addr", 32'(mem_addr), 32'(prev_addr));
        check("stall_data", 32'(mem_wdata), 32'(prev_data));
      end

      if (abort_at >= 0 && nwr == abort_at) begin
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_we", 32'(mem_we), 0);
        check("rst_done", 32'(done), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_wdata", 32'(mem_wdata), 0);
        repeat (3) begin
          @(negedge clk);
          check("rst_hold_done", 32'(done), 0);
          check("rst_hold_we", 32'(mem_we), 0);
        end
        reset = 1'b1;
        repeat (2) begin
          @(negedge clk);
          check("post_rst_done", 32'(done), 0);
          check("post_rst_we", 32'(mem_we), 0);
        end
        check("post_rst_ready", 32'(in_ready), 1);
        fin = 1;
      end else if (done) begin
        check("done_all_written", 32'(exp_q.size()), 0);
        check("done_we", 32'(mem_we), 0);
        if (mode == 0) check("done_latency", 32'(cyc), NPIX + 1);
        in_valid = 1'b0;
        fin = 1;
      end else begin
        if (mem_we && mem_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_write", 32'(mem_we), 0);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(mem_addr), e.addr);
            check("wr_data", 32'(mem_wdata), 32'(e.data));
            nwr++;
          end
        end
        prev_stall = mem_we && !mem_ready;
        prev_addr  = mem_addr;
        prev_data  = mem_wdata;
        if (cyc > 4 * NPIX) begin
          check("timeout_done", 32'(done), 1);
          in_valid = 1'b0;
          fin = 1;
        end
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    mem_ready = 1'b0;
    mbnumber  = '0;
    for (int i = 0; i < NPIX; i++) mb[i] = '0;

    repeat (3) @(negedge clk);
    check("reset_we", 32'(mem_we), 0);
    check("reset_done", 32'(done), 0);
    check("reset_addr", 32'(mem_addr), 0);
    check("reset_wdata", 32'(mem_wdata), 0);
    reset = 1'b1;
    @(negedge clk);
    check("release_ready", 32'(in_ready), 1);

    run_block(0, 0, 0, 1'b1, -1, 1'b0);
    run_block(32, 48, 1, 1'b0, -1, 1'b0);
    run_block(712, 1272, 0, 1'b0, -1, 1'b0);
    run_block(100, 200, 2, 1'b0, 100, 1'b0);
    run_block(100, 200, 0, 1'b0, -1, 1'b0);
    run_block(400, 640, 0, 1'b0, -1, 1'b1);
    run_block(64, 1264, 2, 1'b0, -1, 1'b0);
    repeat (6)
      run_block(int'($urandom_range(0, LENGTH + 8)), int'($urandom_range(0, WIDTH + 8)),
                int'($urandom_range(0, 2)), 1'b0, -1, 1'b0);

    @(negedge clk);
    check("final_done_low", 32'(done), 0);
    check("final_ready", 32'(in_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mb_writer.md
MB_WRITER -- requirements
Module: mb_writer

Interface
REQ-001 SHALL have parameter WIDTH, default 1280: frame width in pixels (row pitch).
REQ-002 SHALL have parameter LENGTH, default 720: frame height in pixels.
REQ-003 SHALL have parameters MB_SIZE_L and MB_SIZE_W, default 16 each: macroblock rows and columns.
REQ-004 SHALL have localparam ADDR_W = $clog2(WIDTH*LENGTH).
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  macroblock and mbnumber presented.
REQ-008 in_ready  output  1  block can accept a macroblock.
REQ-009 mbnumber  input  32  [31:16] top-left pixel row, [15:0] top-left pixel column.
REQ-010 mb  input  8 x (MB_SIZE_L*MB_SIZE_W) array  pixels, index j*MB_SIZE_W+k, row j, column k.
REQ-011 mem_we  output  1  frame-memory write strobe.
REQ-012 mem_addr  output  ADDR_W  frame-memory pixel address.
REQ-013 mem_wdata  output  8  pixel to write.
REQ-014 mem_ready  input  1  memory accepts the current write this cycle.
REQ-015 done  output  1  one-cycle pulse, macroblock fully written.

Function
REQ-016 States: IDLE, WRITE, DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; a transfer occurs when in_valid and in_ready are both 1 on a rising edge.
REQ-018 On transfer: latch all mb pixels and mbnumber into an internal buffer, clear j and k, go to WRITE.
REQ-019 In WRITE, pixel (j,k) SHALL be presented with mem_addr = (row+j)*WIDTH + (col+k) and mem_wdata = buffer[j*MB_SIZE_W+k].
REQ-020 Arithmetic SHALL use at least 32 bits internally and be truncated to ADDR_W only at the output.
REQ-021 Pixels with row+j >= LENGTH or col+k >= WIDTH SHALL be clipped: mem_we=0, counters advance that cycle without waiting for mem_ready.
REQ-022 For in-frame pixels, mem_we=1; counters advance only on a cycle with mem_ready=1; otherwise mem_we, mem_addr and mem_wdata hold unchanged.
REQ-023 Scan order: k increments 0..MB_SIZE_W-1, then wraps to 0 with j incremented; raster order.
REQ-024 After pixel (MB_SIZE_L-1, MB_SIZE_W-1) advances, go to DONE; DONE asserts done for exactly one cycle and returns to IDLE.
REQ-025 Latency: first write is presented the cycle after transfer; with mem_ready held 1 and no clipping, done asserts MB_SIZE_L*MB_SIZE_W+1 cycles after transfer.
REQ-026 mem_we SHALL be 0 in IDLE and DONE; mb input changes after transfer SHALL NOT affect written data.
REQ-027 in_valid while not in IDLE SHALL be ignored and not transferred.

Reset
REQ-028 Reset low SHALL immediately force IDLE, j=k=0, mem_we=0, done=0, mem_addr=0, mem_wdata=0; in_ready becomes 1 once reset is released.
REQ-029 Reset asserted mid-WRITE SHALL abandon the macroblock with no further writes and no done pulse.

Structure
REQ-030 Package intra_pkg SHALL hold MB_SIZE_L, MB_SIZE_W defaults and the state enum mb_wr_state_t, shared with the macroblock extractor.
REQ-031 One sub-module mb_addr_gen SHALL compute mem_addr and the clip flag from row, col, j, k.

Verification
REQ-032 mbnumber={16'd0,16'd0}, mb[i]=i, mem_ready=1 -> 256 writes, addr j*1280+k, data j*16+k, done at cycle 257 after transfer.
REQ-033 mbnumber={16'd32,16'd48}, mem_ready toggling 1/0 -> each address written exactly once in raster order, outputs stable during stalls, first addr 41008.
REQ-034 mbnumber={16'd712,16'd1272} -> only 64 writes (j<8, k<8), clipped cycles mem_we=0, done still pulses once.
REQ-035 Reset low at write 100 -> mem_we=0 immediately, no done, in_ready=1 after release, next macroblock writes fully.
REQ-036 in_valid held 1 with changing mb during WRITE -> second block accepted only after done, first block data unaffected.
